fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction fetch sequencer for the 8-bit core, sitting between the program counter, the combinational instruction ROM (`instr`/`imm` pair at `addr`/`addr+1`) and the decode stage.
- Owns the PC and drives the ROM address.
- Detects whether the current opcode carries an immediate, and advances the PC by 1 or 2 accordingly.
- Presents one registered instruction/immediate bundle per cycle to decode under a valid/ready handshake, with branch redirect and run/stop control.

Parameters:
- WORD_W, 8, instruction/data word width.
- ADDR_W, 8, ROM address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- IMM_OPMASK, 16'h0002, bitmap indexed by opcode `instr[7:4]`; a set bit means the opcode is followed by an immediate word (bit 1 = ADDI).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 stops new fetches.
- mem_addr  out  ADDR_W  ROM address; equals the current PC combinationally.
- mem_instr  in  WORD_W  ROM word at mem_addr, same cycle.
- mem_imm  in  WORD_W  ROM word at mem_addr+1, same cycle.
- br_valid  in  1  branch redirect request.
- br_target  in  ADDR_W  redirect address.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  decode accepts the bundle.
- out_instr  out  WORD_W  fetched instruction.
- out_imm  out  WORD_W  immediate, or 0 if the opcode has none.
- out_pc  out  ADDR_W  address of out_instr.
- retired  out  16  count of accepted bundles; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC; state=IDLE.
  - out_valid=0, out_instr=0, out_imm=0, out_pc=0, retired=0.
  - rst has priority over every other input, br_valid included.
- States: IDLE, FETCH, STALL.
  - IDLE → FETCH when run=1.
  - FETCH → STALL when a bundle is valid and out_ready=0.
  - STALL → FETCH when out_ready=1 and run=1.
  - STALL → IDLE when out_ready=1 and run=0.
  - FETCH → IDLE when run=0 and the output is empty or being consumed.
- Handshake: a transfer occurs in a cycle where out_valid=1 and out_ready=1.
- Capture condition: state≠IDLE, run=1, br_valid=0, and (out_valid=0 or a transfer occurs this cycle).
- On capture, with has_imm = IMM_OPMASK[mem_instr[7:4]]:
  - out_instr←mem_instr; out_pc←pc; out_imm←(has_imm ? mem_imm : 0); out_valid←1.
  - pc←pc+1, or pc+2 when has_imm, truncated to ADDR_W.
  - Zero bubble: sustains 1 bundle/cycle while out_ready=1.
- No capture, but a transfer occurs: out_valid←0.
- Backpressure (out_valid=1, out_ready=0):
  - out_instr, out_imm, out_pc and pc are all held.
  - mem_addr is stable.
- Branch (br_valid=1, rst=0):
  - pc←br_target; out_valid←0 (flush); no capture that cycle.
  - Branch and transfer in the same cycle: the transfer counts (retired increments), then the bundle is flushed.
  - Branch in IDLE loads the PC; state stays IDLE.
- retired increments on each transfer and holds at 16'hFFFF.
- run=0 mid-stream: any pending bundle stays valid until transferred; no further captures.
- Wrap-around:
  - An immediate opcode at pc=2^ADDR_W−1 reads its immediate from address 0; the ROM wraps addr+1.
  - Next pc=1.
  - Plain opcode at pc=2^ADDR_W−1: next pc=0.
- No latency from mem_addr to capture: the ROM is combinational, so the bundle is registered at the end of the same cycle.

Test Plan:
- ROM[0..3]=00,10,FF,30; rst then run=1, out_ready=1 → consecutive bundles (pc,instr,imm)=(00,00,00),(01,10,FF),(03,30,00); mem_addr sequence 00,01,03,04; retired=3 after the third transfer.
- Same program, out_ready=0 for 3 cycles while bundle pc=01 is valid → out_instr=10, out_imm=FF, mem_addr=03 stable for all 3 cycles; bundle pc=03 appears the cycle after out_ready=1.
- br_valid=1, br_target=40 while bundle pc=01 is valid and out_ready=0 → next cycle out_valid=0 and mem_addr=40; following cycle out_pc=40; retired unchanged.
- br_target=FF with ROM[FF]=10, ROM[00]=AA → bundle pc=FF, imm=AA; next mem_addr=01.
- Mid-stream rst=1 together with br_valid=1, target=40 → next cycle out_valid=0, mem_addr=00, retired=0, state IDLE (no capture while run=1 until the following cycle).
- run dropped while bundle pc=03 is valid and out_ready=0 → bundle held; after out_ready=1, out_valid=0, no new capture, mem_addr frozen at 04.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: ROM access, branch redirect and decode handshake bundle for fetch_ctrl
interface fetch_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_instr;
  logic [WORD_W-1:0] mem_imm;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_pc;
  modport master (
    output mem_addr, out_valid, out_instr, out_imm, out_pc,
    input  mem_instr, mem_imm, br_valid, br_target, out_ready
  );
  modport slave (
    input  mem_addr, out_valid, out_instr, out_imm, out_pc,
    output mem_instr, mem_imm, br_valid, br_target, out_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and fetch sequencer delivering registered instr/imm bundles to decode
module fetch_ctrl #(
  parameter int                WORD_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [15:0]       IMM_OPMASK = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  fetch_if.master     bus,
  output logic [15:0] retired
);
  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              xfer;
  logic              cap;
  logic              has_imm;
  assign bus.mem_addr = pc;
  assign xfer    = bus.out_valid && bus.out_ready;
  assign cap     = state != IDLE && run && !bus.br_valid && (!bus.out_valid || xfer);
  assign has_imm = IMM_OPMASK[bus.mem_instr[WORD_W-1:WORD_W-4]];
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_imm   <= '0;
      bus.out_pc    <= '0;
      retired       <= '0;
    end else begin
      if (xfer && retired != 16'hFFFF) retired <= retired + 16'd1;
      if (state == IDLE) state <= run && !bus.br_valid ? FETCH : IDLE;
      else state <= !run && (!bus.out_valid || xfer) ? IDLE :
                    bus.out_valid && !bus.out_ready && !bus.br_valid ? STALL : FETCH;
      if (cap) begin
        bus.out_instr <= bus.mem_instr;
        bus.out_imm   <= has_imm ? bus.mem_imm : '0;
        bus.out_pc    <= pc;
        bus.out_valid <= 1'b1;
        pc            <= pc + {{(ADDR_W-2){1'b0}}, has_imm, !has_imm};
      end else if (xfer || bus.br_valid) bus.out_valid <= 1'b0;
      // a redirect overrides any PC advance and flushes the bundle
      if (bus.br_valid) pc <= bus.br_target;
    end
  end
endmodule
